stoch_prog_gain_div_mat: RTL and testbench

STOCH_PROG_GAIN_DIV_MAT -- requirements
Module: stoch_prog_gain_div_mat

---
 rtl/stoch_prog_gain_div_mat_pkg.sv | 22 ++
 rtl/stoch_prog_gain_div_mat_elem.sv | 59 +++++
 rtl/stoch_prog_gain_div_mat.sv | 115 +++++++++++
 tb/tb_stoch_prog_gain_div_mat.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stoch_prog_gain_div_mat_pkg.sv
// Shared definitions for the stochastic programmable-gain divider matrix.
//
// Contents:
//   div_state_t   - control FSM states (RUN accepts data, LOAD applies a new gain)
//   GAIN_ILLEGAL  - the one gain value that a load request may not install
//   gain_is_legal - helper used by the control logic to classify GAIN_IN
package stoch_prog_gain_div_mat_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } div_state_t;

  // A gain of zero would make every element emit a 1 forever without ever
  // consuming residue, so it is rejected at load time.
  localparam int unsigned GAIN_ILLEGAL = 0;

  function automatic logic gain_is_legal(input int unsigned gain);
    return gain != GAIN_ILLEGAL;
  endfunction

endpackage

// File: rtl/stoch_prog_gain_div_mat_elem.sv
// One element of the stochastic divider matrix.
//
// Accumulates accepted input bits into a residue counter and emits a 1 each
// time the residue reaches the shared gain, subtracting the gain back out.
// Over a long stream the density of ones on y is the density on a divided
// by gain.
//
// Ports:
//   clk     - rising-edge clock
//   n_rst   - synchronous active-low reset (clears residue and output)
//   accept  - a is consumed this cycle
//   clear   - drop residue (gain change); takes priority over accept
//   a       - stochastic input bit
//   gain    - active gain, shared across the matrix, never zero
//   y       - registered output bit, 0 whenever nothing was accepted
module stoch_prog_gain_div_elem
  import stoch_prog_gain_div_mat_pkg::*;
#(
  parameter int unsigned COUNTER_SIZE = 8,
  parameter int unsigned GAIN_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  accept,
  input  logic                  clear,
  input  logic                  a,
  input  logic [GAIN_WIDTH-1:0] gain,
  output logic                  y
);

  logic [COUNTER_SIZE-1:0] cnt;
  logic [COUNTER_SIZE:0]   sum;
  logic [COUNTER_SIZE:0]   gain_ext;
  logic                    hit;

  // One extra bit on the sum: residue is at most gain-1, so residue+1 can
  // reach gain (<= 2^GAIN_WIDTH-1) and never wraps.
  always_comb begin
    gain_ext = (COUNTER_SIZE+1)'(gain);
    sum      = {1'b0, cnt} + {{COUNTER_SIZE{1'b0}}, a};
    hit      = (sum >= gain_ext);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt <= '0;
      y   <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
      y   <= 1'b0;
    end else if (accept) begin
      y   <= hit;
      cnt <= hit ? COUNTER_SIZE'(sum - gain_ext) : COUNTER_SIZE'(sum);
    end else begin
      y   <= 1'b0;
    end
  end

endmodule

// File: rtl/stoch_prog_gain_div_mat.sv
// Matrix of stochastic dividers with a run-time programmable common gain.
//
// Every element of A (row-major, element (i,j) at bit i*NUM_COLS+j) is fed
// to its own residue-counter divider; all elements share GAIN_CUR. A gain
// load takes the block through a single LOAD cycle in which input is
// refused, all residues are cleared and the new gain becomes active.
//
// Ports:
//   CLK      - rising-edge clock
//   nRST     - synchronous active-low reset
//   A        - stochastic input bits, NUM_ROWS*NUM_COLS wide
//   EN       - A is valid this cycle
//   GAIN_IN  - gain to load
//   GAIN_LD  - single-cycle load strobe for GAIN_IN
//   READY    - high while EN can be accepted
//   Y        - divided stochastic bits, same layout as A, one cycle latency
//   Y_VALID  - Y carries an accepted sample this cycle
//   ERR      - one-cycle pulse after a load request with GAIN_IN == 0
//   GAIN_CUR - currently active gain
module stoch_prog_gain_div_mat
  import stoch_prog_gain_div_mat_pkg::*;
#(
  parameter int unsigned COUNTER_SIZE = 8,
  parameter int unsigned GAIN_WIDTH   = 4,
  parameter int unsigned NUM_ROWS     = 2,
  parameter int unsigned NUM_COLS     = 2,
  parameter int unsigned DEFAULT_GAIN = 2
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic [NUM_ROWS*NUM_COLS-1:0] A,
  input  logic                         EN,
  input  logic [GAIN_WIDTH-1:0]        GAIN_IN,
  input  logic                         GAIN_LD,
  output logic                         READY,
  output logic [NUM_ROWS*NUM_COLS-1:0] Y,
  output logic                         Y_VALID,
  output logic                         ERR,
  output logic [GAIN_WIDTH-1:0]        GAIN_CUR
);

  div_state_t            state;
  logic [GAIN_WIDTH-1:0] gain_pend;
  logic                  gain_ok;
  logic                  load_req;
  logic                  accept;
  logic                  clear;

  // A legal load request pre-empts the sample presented in the same cycle.
  always_comb begin
    gain_ok  = gain_is_legal(32'(GAIN_IN));
    load_req = (state == ST_RUN) && GAIN_LD && gain_ok;
    accept   = (state == ST_RUN) && EN && !load_req;
    clear    = (state == ST_LOAD);
  end

  // The new gain is parked in gain_pend on entry to LOAD and becomes active
  // on the LOAD edge, together with the residue clear in every element, so
  // no element ever sees a residue computed under a different gain.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= ST_RUN;
      GAIN_CUR  <= GAIN_WIDTH'(DEFAULT_GAIN);
      gain_pend <= GAIN_WIDTH'(DEFAULT_GAIN);
      READY     <= 1'b1;
      ERR       <= 1'b0;
      Y_VALID   <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          ERR     <= GAIN_LD && !gain_ok;
          Y_VALID <= accept;
          if (load_req) begin
            state     <= ST_LOAD;
            gain_pend <= GAIN_IN;
            READY     <= 1'b0;
          end else begin
            READY     <= 1'b1;
          end
        end
        ST_LOAD: begin
          GAIN_CUR <= gain_pend;
          state    <= ST_RUN;
          READY    <= 1'b1;
          ERR      <= 1'b0;
          Y_VALID  <= 1'b0;
        end
        default: begin
          state    <= ST_RUN;
          READY    <= 1'b1;
          ERR      <= 1'b0;
          Y_VALID  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    for (genvar col = 0; col < NUM_COLS; col++) begin : g_col
      stoch_prog_gain_div_elem #(
        .COUNTER_SIZE (COUNTER_SIZE),
        .GAIN_WIDTH   (GAIN_WIDTH)
      ) u_elem (
        .clk    (CLK),
        .n_rst  (nRST),
        .accept (accept),
        .clear  (clear),
        .a      (A[r*NUM_COLS+col]),
        .gain   (GAIN_CUR),
        .y      (Y[r*NUM_COLS+col])
      );
    end
  end

endmodule

// File: tb/tb_stoch_prog_gain_div_mat.sv
module tb_stoch_prog_gain_div_mat;

  localparam int CS  = 8;
  localparam int GW  = 4;
  localparam int NR  = 2;
  localparam int NC  = 2;
  localparam int N   = NR * NC;
  localparam int DEF = 2;

  logic          CLK;
  logic          nRST;
  logic [N-1:0]  A;
  logic          EN;
  logic [GW-1:0] GAIN_IN;
  logic          GAIN_LD;
  logic          READY;
  logic [N-1:0]  Y;
  logic          Y_VALID;
  logic          ERR;
  logic [GW-1:0] GAIN_CUR;

  int n_checks = 0;
  int n_errors = 0;

  stoch_prog_gain_div_mat #(
    .COUNTER_SIZE (CS),
    .GAIN_WIDTH   (GW),
    .NUM_ROWS     (NR),
    .NUM_COLS     (NC),
    .DEFAULT_GAIN (DEF)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .A        (A),
    .EN       (EN),
    .GAIN_IN  (GAIN_IN),
    .GAIN_LD  (GAIN_LD),
    .READY    (READY),
    .Y        (Y),
    .Y_VALID  (Y_VALID),
    .ERR      (ERR),
    .GAIN_CUR (GAIN_CUR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // Division semantics from the rules: each element keeps a residue, adds the
  // accepted bit, emits 1 and subtracts the gain once the gain is reached.
  // A legal load makes the block busy for one cycle, after which residues
  // are zero and the new gain is in force.
  int           m_cnt [N];
  int           m_gain;
  int           m_pend;
  bit           m_busy;
  bit           m_known = 1'b0;
  logic [N-1:0] e_y;
  logic         e_yv, e_err, e_ready;

  always @(posedge CLK) begin
    if (!nRST) begin
      m_known = 1'b1;
      m_busy  = 1'b0;
      m_gain  = DEF;
      foreach (m_cnt[e]) m_cnt[e] = 0;
      e_y = '0; e_yv = 1'b0; e_err = 1'b0; e_ready = 1'b1;
    end else if (m_busy) begin
      m_busy = 1'b0;
      m_gain = m_pend;
      foreach (m_cnt[e]) m_cnt[e] = 0;
      e_y = '0; e_yv = 1'b0; e_err = 1'b0; e_ready = 1'b1;
    end else begin
      e_err   = GAIN_LD && (GAIN_IN == 0);
      e_ready = 1'b1;
      e_y     = '0;
      e_yv    = 1'b0;
      if (GAIN_LD && GAIN_IN != 0) begin
        m_busy  = 1'b1;
        m_pend  = int'(GAIN_IN);
        e_ready = 1'b0;
      end else if (EN) begin
        e_yv = 1'b1;
        for (int e = 0; e < N; e++) begin
          int s;
          s = m_cnt[e] + int'(A[e]);
          if (s >= m_gain) begin
            e_y[e]   = 1'b1;
            m_cnt[e] = s - m_gain;
          end else begin
            m_cnt[e] = s;
          end
        end
      end
    end
    #1;
    if (m_known) begin
      check("model_y",       32'(Y),        32'(e_y));
      check("model_y_valid", 32'(Y_VALID),  32'(e_yv));
      check("model_err",     32'(ERR),      32'(e_err));
      check("model_ready",   32'(READY),    32'(e_ready));
      check("model_gain",    32'(GAIN_CUR), m_gain);
    end
  end

  // ---------------- stimulus + literal expectations ----------------
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  logic [N-1:0] prev_a;

  initial begin
    nRST = 1'b0; EN = 1'b0; A = '0; GAIN_LD = 1'b0; GAIN_IN = '0;
    tick(); tick();
    check("rst_ready",   32'(READY),    1);
    check("rst_gain",    32'(GAIN_CUR), 2);
    check("rst_y_valid", 32'(Y_VALID),  0);
    check("rst_y",       32'(Y),        0);
    check("rst_err",     32'(ERR),      0);
    nRST = 1'b1;

    // gain 2, all ones: 0,1,0,1,...
    EN = 1'b1; A = '1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("g2_y",       32'(Y),       (k % 2 == 1) ? 15 : 0);
      check("g2_y_valid", 32'(Y_VALID), 1);
    end
    EN = 1'b0; A = '0;
    tick();
    check("idle_y_valid", 32'(Y_VALID), 0);
    check("idle_y",       32'(Y),       0);

    // load gain 3, element 0 only: 0,0,1 repeating
    GAIN_LD = 1'b1; GAIN_IN = 4'd3;
    tick();
    check("ld3_ready_low", 32'(READY), 0);
    GAIN_LD = 1'b0; GAIN_IN = '0;
    tick();
    check("ld3_ready_high", 32'(READY),    1);
    check("ld3_gain",       32'(GAIN_CUR), 3);
    EN = 1'b1; A = 4'b0001;
    for (int k = 0; k < 9; k++) begin
      tick();
      check("g3_y", 32'(Y), (k % 3 == 2) ? 1 : 0);
    end

    // illegal load mid-stream
    A = '1; GAIN_LD = 1'b1; GAIN_IN = '0;
    tick();
    check("err_pulse",   32'(ERR),      1);
    check("err_gain",    32'(GAIN_CUR), 3);
    check("err_y_valid", 32'(Y_VALID),  1);
    check("err_y",       32'(Y),        0);
    GAIN_LD = 1'b0;
    tick();
    check("err_clear", 32'(ERR),   0);
    check("err_y2",    32'(Y),     0);
    check("err_ready", 32'(READY), 1);
    tick();
    check("err_y3", 32'(Y), 15);
    tick();
    check("pre_ld_y", 32'(Y), 0);   // residue now 1 everywhere

    // load together with EN: sample dropped, residues cleared
    GAIN_LD = 1'b1; GAIN_IN = 4'd2;
    tick();
    check("drop_y_valid", 32'(Y_VALID), 0);
    check("drop_ready",   32'(READY),   0);
    GAIN_LD = 1'b0;
    tick();
    check("drop_load_y_valid", 32'(Y_VALID),  0);
    check("drop_gain",         32'(GAIN_CUR), 2);
    tick();
    check("drop_first_y", 32'(Y), 0);
    tick();
    check("drop_second_y", 32'(Y), 15);

    // residue 2 under gain 3, then reset
    EN = 1'b0; GAIN_LD = 1'b1; GAIN_IN = 4'd3;
    tick();
    GAIN_LD = 1'b0;
    tick();
    EN = 1'b1; A = '1;
    tick(); tick();
    check("res2_y", 32'(Y), 0);
    nRST = 1'b0;
    tick();
    check("mrst_y",       32'(Y),        0);
    check("mrst_y_valid", 32'(Y_VALID),  0);
    check("mrst_gain",    32'(GAIN_CUR), 2);
    nRST = 1'b1;
    tick();
    check("mrst_first_y", 32'(Y),       0);
    check("mrst_first_v", 32'(Y_VALID), 1);

    // reset during LOAD discards the pending gain
    EN = 1'b0; GAIN_LD = 1'b1; GAIN_IN = 4'd5;
    tick();
    GAIN_LD = 1'b0; nRST = 1'b0;
    tick();
    nRST = 1'b1;
    tick();
    check("rstload_gain",  32'(GAIN_CUR), 2);
    check("rstload_ready", 32'(READY),    1);

    // gain 1: transparent with one cycle delay
    GAIN_LD = 1'b1; GAIN_IN = 4'd1;
    tick();
    GAIN_LD = 1'b0;
    tick();
    EN = 1'b1;
    for (int k = 0; k < 64; k++) begin
      A = N'($urandom);
      prev_a = A;
      tick();
      check("g1_passthru", 32'(Y), 32'(prev_a));
    end

    // random traffic, occasional loads (incl. illegal) and resets
    for (int k = 0; k < 400; k++) begin
      EN      = ($urandom_range(0, 3) != 0);
      A       = N'($urandom);
      GAIN_LD = ($urandom_range(0, 15) == 0);
      GAIN_IN = GW'($urandom_range(0, 15));
      nRST    = ($urandom_range(0, 63) != 0);
      tick();
    end
    nRST = 1'b1; EN = 1'b0; GAIN_LD = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
